tcp_tx_scheduler: RTL and testbench
===================================

TCP_TX_SCHEDULER -- requirements
Module: tcp_tx_scheduler

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 The module SHALL have parameter DEFAULT_RTO, default 16'h2000, giving the retransmit timeout in cycles used when timeout_rto_in is 0.
REQ-003 The module SHALL have parameter MAX_RETRIES, default 3, giving the number of retransmissions allowed per SYN or FIN.
REQ-004 The module SHALL have these ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- timeout_rto_in  in  16  retransmit timeout in cycles; 0 selects DEFAULT_RTO
- syn_send  in  1  single-cycle SYN request from the connection FSM
- fin_send  in  1  single-cycle FIN request
- ack_send  in  1  single-cycle ACK request
- syn_ack_rcvd  in  1  peer acknowledged our SYN
- fin_ack_rcvd  in  1  peer acknowledged our FIN
- data_req  in  1  payload ready; level signal
- data_grant  out  1  one-cycle pulse when a data segment is accepted
- seg_valid  out  1  segment request to the packet builder
- seg_ready  in  1  packet builder accepts the segment
- seg_flags  out  3  {SYN,FIN,ACK}
- seg_is_data  out  1  segment carries payload
- pending_out  out  3  pending {SYN,FIN,ACK} bits
- retry_exhausted  out  1  one-cycle pulse when retries are exhausted

Function
REQ-005 The module SHALL set the pending bit for SYN, FIN or ACK in the cycle after that bit's request input pulses; pending_out SHALL mirror the pending bits.
REQ-006 The scheduler FSM SHALL have two states:
- IDLE: if any pending bit is set or data_req=1, load the segment registers and go to ISSUE next cycle.
- ISSUE: hold seg_valid=1; seg_flags and seg_is_data SHALL stay stable until seg_valid&&seg_ready, then return to IDLE.
REQ-007 Selection priority SHALL be SYN > FIN > ACK > data.
REQ-008 A SYN or FIN segment SHALL carry ACK=1 when ACK is pending at load time.
REQ-009 A data segment SHALL have seg_is_data=1 and seg_flags=3'b001.
REQ-010 An ACK-only segment SHALL have seg_flags=3'b001 and seg_is_data=0.
REQ-011 On acceptance, the pending bits carried by the segment SHALL clear; a request pulse for the same bit in the acceptance cycle SHALL win, and that bit SHALL stay pending.
REQ-012 data_grant SHALL pulse for one cycle in the acceptance cycle of a data segment only.
REQ-013 Issue latency SHALL be 2 cycles from a request pulse to seg_valid, with seg_ready held high.
REQ-014 The minimum spacing between consecutive acceptances SHALL be 2 cycles, one of which is an IDLE cycle.
REQ-015 Acceptance of a SYN or FIN segment SHALL clear the 16-bit retransmit timer and arm it for that flag. SYN SHALL take precedence if both are outstanding; arming FIN while SYN is outstanding SHALL be ignored.
REQ-016 While armed, the timer SHALL increment each cycle and saturate at the effective timeout.
REQ-017 Timeout SHALL be hit when timer >= effective timeout. On a hit, the module SHALL re-set the armed flag's pending bit, increment the retry count, clear the timer and re-arm.
REQ-018 A hit with retry count == MAX_RETRIES SHALL instead pulse retry_exhausted, disarm the timer and clear the retry count, and SHALL NOT re-set the pending bit.
REQ-019 syn_ack_rcvd while SYN is armed, or fin_ack_rcvd while FIN is armed, SHALL disarm the timer and clear the retry count. Acknowledgement SHALL take precedence over a hit in the same cycle.
REQ-020 Acknowledgement inputs that do not match the armed flag SHALL be ignored.
REQ-021 The retry counter SHALL be wide enough for MAX_RETRIES and SHALL never wrap.
REQ-022 A change of timeout_rto_in SHALL take effect on the next compare.

Reset
REQ-023 When rst_n=0, the module SHALL asynchronously clear the FSM to IDLE, clear pending bits, timer, retry count and armed state, and drive seg_valid, seg_flags, seg_is_data, data_grant, pending_out and retry_exhausted to 0.
REQ-024 A reset asserted during ISSUE SHALL drop seg_valid immediately, and the segment SHALL NOT be reissued after reset.

Verification
REQ-025 The bench SHALL cover: ack_send pulse at t0, seg_ready=1 -> seg_valid at t0+2, flags=001, is_data=0, pending_out returns to 000.
REQ-026 The bench SHALL cover: syn_send and ack_send in the same cycle plus data_req=1 -> first segment flags=101, second segment is data with flags=001, data_grant pulses once.
REQ-027 The bench SHALL cover: seg_ready held 0 for 5 cycles during ISSUE -> seg_valid, flags and is_data stable; ack_send pulsed meanwhile -> ACK pending after acceptance.
REQ-028 The bench SHALL cover: timeout_rto_in=16, SYN accepted, no syn_ack_rcvd -> SYN reissued 3 times at about 16+2 cycle intervals, then a single retry_exhausted pulse and pending SYN=0.
REQ-029 The bench SHALL cover: FIN accepted, fin_ack_rcvd in the same cycle as the timeout hit -> no FIN reissue, timer disarmed.
REQ-030 The bench SHALL cover: rst_n deasserted mid-ISSUE with seg_ready=0 -> all outputs 0 immediately, and no segment issued after release without a new request.

Source files
------------

// File: rtl/tcp_tx_scheduler.sv
// ============================================================================
//  Module   : tcp_tx_scheduler
//  Brief    : Arbitrates SYN/FIN/ACK control segments and payload segments
//             toward the packet builder and runs the SYN/FIN retransmit
//             timer with a bounded retry count.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tcp_tx_scheduler #(
    parameter logic [15:0] DEFAULT_RTO = 16'h2000,
    parameter int          MAX_RETRIES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] timeout_rto_in,
    input  logic        syn_send,
    input  logic        fin_send,
    input  logic        ack_send,
    input  logic        syn_ack_rcvd,
    input  logic        fin_ack_rcvd,
    input  logic        data_req,
    output logic        data_grant,
    output logic        seg_valid,
    input  logic        seg_ready,
    output logic [2:0]  seg_flags,
    output logic        seg_is_data,
    output logic [2:0]  pending_out,
    output logic        retry_exhausted
);

    localparam int c_RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
    localparam logic [c_RW-1:0] c_MAX_RETRIES = c_RW'(MAX_RETRIES);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t            r_state;
    logic [2:0]        r_pending;      // {SYN, FIN, ACK}
    logic [15:0]       r_timer;
    logic              r_armed;
    logic              r_armed_syn;    // 1: timer guards SYN, 0: guards FIN
    logic [c_RW-1:0]   r_retries;
    logic              r_exhausted;

    logic [2:0]        w_req;
    logic              w_accept;
    logic [2:0]        w_carried;
    logic [15:0]       w_rto;
    logic              w_hit;
    logic              w_ack_match;
    logic              w_arm_syn;
    logic              w_arm_fin;
    logic              w_arm;
    logic              w_hit_eff;
    logic              w_retry;
    logic              w_exhaust;
    logic [2:0]        w_reissue;

    assign w_req       = {syn_send, fin_send, ack_send};
    assign w_accept    = seg_valid & seg_ready;
    // Data segments carry ACK in the header but never own the pending ACK bit
    assign w_carried   = (w_accept && !seg_is_data) ? seg_flags : 3'b000;
    assign w_rto       = (timeout_rto_in == 16'd0) ? DEFAULT_RTO : timeout_rto_in;
    assign w_hit       = r_armed && (r_timer >= w_rto);
    assign w_ack_match = r_armed && (r_armed_syn ? syn_ack_rcvd : fin_ack_rcvd);
    assign w_arm_syn   = w_accept && seg_flags[2];
    // A FIN cannot steal the timer from an outstanding SYN
    assign w_arm_fin   = w_accept && seg_flags[1] && !(r_armed && r_armed_syn);
    assign w_arm       = w_arm_syn | w_arm_fin;
    // An acknowledgement or a fresh arm outranks a timeout in the same cycle
    assign w_hit_eff   = w_hit && !w_ack_match && !w_arm;
    assign w_retry     = w_hit_eff && (r_retries != c_MAX_RETRIES);
    assign w_exhaust   = w_hit_eff && (r_retries == c_MAX_RETRIES);
    assign w_reissue   = w_retry ? (r_armed_syn ? 3'b100 : 3'b010) : 3'b000;

    assign pending_out     = r_pending;
    assign data_grant      = w_accept & seg_is_data;
    assign retry_exhausted = r_exhausted;

    // Pending bits: new requests and retransmits set, accepted segments clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 3'b000;
        end else begin
            r_pending <= (r_pending & ~w_carried) | w_req | w_reissue;
        end
    end

    // Scheduler FSM: pick the highest-priority work and hold it until accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            seg_valid   <= 1'b0;
            seg_flags   <= 3'b000;
            seg_is_data <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_pending[2]) begin
                        r_state     <= S_ISSUE;
                        seg_valid   <= 1'b1;
                        seg_flags   <= {2'b10, r_pending[0]};
                        seg_is_data <= 1'b0;
                    end else if (r_pending[1]) begin
                        r_state     <= S_ISSUE;
                        seg_valid   <= 1'b1;
                        seg_flags   <= {2'b01, r_pending[0]};
                        seg_is_data <= 1'b0;
                    end else if (r_pending[0]) begin
                        r_state     <= S_ISSUE;
                        seg_valid   <= 1'b1;
                        seg_flags   <= 3'b001;
                        seg_is_data <= 1'b0;
                    end else if (data_req && (w_req == 3'b000)) begin
                        // Control requests arriving now become pending next
                        // cycle and must still outrank payload
                        r_state     <= S_ISSUE;
                        seg_valid   <= 1'b1;
                        seg_flags   <= 3'b001;
                        seg_is_data <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (seg_ready) begin
                        r_state   <= S_IDLE;
                        seg_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    seg_valid <= 1'b0;
                end
            endcase
        end
    end

    // Retransmit timer, armed flag and retry counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer     <= 16'd0;
            r_armed     <= 1'b0;
            r_armed_syn <= 1'b0;
            r_retries   <= '0;
            r_exhausted <= 1'b0;
        end else begin
            r_exhausted <= w_exhaust;
            if (w_arm) begin
                r_armed     <= 1'b1;
                r_armed_syn <= w_arm_syn;
                r_timer     <= 16'd0;
                // Retransmissions of the same flag keep their retry history
                if (!r_armed || (r_armed_syn != w_arm_syn)) begin
                    r_retries <= '0;
                end
            end else if (w_ack_match) begin
                r_armed   <= 1'b0;
                r_retries <= '0;
                r_timer   <= 16'd0;
            end else if (w_retry) begin
                r_retries <= r_retries + c_RW'(1);
                r_timer   <= 16'd0;
            end else if (w_exhaust) begin
                r_armed   <= 1'b0;
                r_retries <= '0;
                r_timer   <= 16'd0;
            end else if (r_armed && (r_timer < w_rto)) begin
                r_timer <= r_timer + 16'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tcp_tx_scheduler.sv
// ============================================================================
//  Module   : tb_tcp_tx_scheduler
//  Brief    : Self-checking bench for tcp_tx_scheduler (vector table plus
//             scoreboard of expected segments, and directed corner cases).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tcp_tx_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] timeout_rto_in = 16'd0;
    logic        syn_send = 1'b0;
    logic        fin_send = 1'b0;
    logic        ack_send = 1'b0;
    logic        syn_ack_rcvd = 1'b0;
    logic        fin_ack_rcvd = 1'b0;
    logic        data_req = 1'b0;
    logic        seg_ready = 1'b1;
    logic        data_grant;
    logic        seg_valid;
    logic [2:0]  seg_flags;
    logic        seg_is_data;
    logic [2:0]  pending_out;
    logic        retry_exhausted;

    tcp_tx_scheduler #(
        .DEFAULT_RTO (16'h2000),
        .MAX_RETRIES (3)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .timeout_rto_in  (timeout_rto_in),
        .syn_send        (syn_send),
        .fin_send        (fin_send),
        .ack_send        (ack_send),
        .syn_ack_rcvd    (syn_ack_rcvd),
        .fin_ack_rcvd    (fin_ack_rcvd),
        .data_req        (data_req),
        .data_grant      (data_grant),
        .seg_valid       (seg_valid),
        .seg_ready       (seg_ready),
        .seg_flags       (seg_flags),
        .seg_is_data     (seg_is_data),
        .pending_out     (pending_out),
        .retry_exhausted (retry_exhausted)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         grant_cnt = 0;
    int         ex_cnt = 0;
    int         ex_cyc = 0;
    logic [3:0] exp_q[$];   // expected {flags[2:0], is_data} per accepted segment
    int         acc_q[$];   // cycle index of every acceptance
    logic [3:0] e;

    // One record per vector: request pulse, data_req, up to three segments
    typedef struct {
        logic [2:0]  req;    // {syn, fin, ack}
        logic        data;
        int          n;
        logic [11:0] segs;   // segment k at [11-4k -: 4]
    } vec_t;
    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || data_req) && n < 60) begin
            @(negedge clk);
            if (data_grant) begin
                @(posedge clk);
                #1;
                data_req = 1'b0;
            end
            n++;
        end
        chk(name, 32'(n < 60), 32'd1);
        data_req = 1'b0;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every acceptance pops one expected segment
    always @(negedge clk) begin
        if (rst_n && seg_valid && seg_ready) begin
            acc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_seg: got flags=%b is_data=%b want no segment",
                         seg_flags, seg_is_data);
            end else begin
                e = exp_q.pop_front();
                chk("seg", 32'({seg_flags, seg_is_data}), 32'(e));
                chk("data_grant", 32'(data_grant), 32'(e[0]));
            end
        end
        if (data_grant) grant_cnt++;
        if (retry_exhausted) begin
            ex_cnt++;
            ex_cyc = cyc;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int a;

        vecs[0] = '{3'b001, 1'b0, 1, 12'h200};   // ACK only
        vecs[1] = '{3'b100, 1'b0, 1, 12'h800};   // SYN only
        vecs[2] = '{3'b010, 1'b0, 1, 12'h400};   // FIN only
        vecs[3] = '{3'b101, 1'b1, 2, 12'hA30};   // SYN+ACK, then data
        vecs[4] = '{3'b011, 1'b0, 1, 12'h600};   // FIN+ACK
        vecs[5] = '{3'b000, 1'b1, 1, 12'h300};   // data only
        vecs[6] = '{3'b110, 1'b0, 2, 12'h840};   // SYN then FIN
        vecs[7] = '{3'b111, 1'b1, 3, 12'hA43};   // SYN+ACK, FIN, data
        vecs[8] = '{3'b010, 1'b1, 2, 12'h430};   // FIN then data

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(seg_valid), 0);
        chk("rst_flags", 32'(seg_flags), 0);
        chk("rst_is_data", 32'(seg_is_data), 0);
        chk("rst_grant", 32'(data_grant), 0);
        chk("rst_pending", 32'(pending_out), 0);
        chk("rst_exh", 32'(retry_exhausted), 0);
        rst_n = 1'b1;
        tick();

        // ACK latency: pulse in t0, pending in t0+1, seg_valid in t0+2
        exp_q.push_back(4'b0010);
        ack_send = 1'b1;
        @(negedge clk);
        chk("lat_t0_valid", 32'(seg_valid), 0);
        tick();
        ack_send = 1'b0;
        @(negedge clk);
        chk("lat_t1_pend", 32'(pending_out), 32'b001);
        chk("lat_t1_valid", 32'(seg_valid), 0);
        @(negedge clk);
        chk("lat_t2_valid", 32'(seg_valid), 1);
        chk("lat_t2_flags", 32'({seg_flags, seg_is_data}), 32'b0010);
        @(negedge clk);
        chk("lat_t3_pend", 32'(pending_out), 0);
        wait_drain("lat_drain");

        // Vector table
        for (int i = 0; i < 9; i++) begin
            for (int k = 0; k < vecs[i].n; k++)
                exp_q.push_back(vecs[i].segs[11-4*k -: 4]);
            grant_cnt = 0;
            {syn_send, fin_send, ack_send} = vecs[i].req;
            data_req = vecs[i].data;
            tick();
            {syn_send, fin_send, ack_send} = 3'b000;
            wait_drain($sformatf("vec%0d_drain", i));
            repeat (2) tick();
            chk($sformatf("vec%0d_pending", i), 32'(pending_out), 0);
            chk($sformatf("vec%0d_grants", i), 32'(grant_cnt), 32'(vecs[i].data));
            syn_ack_rcvd = 1'b1;
            fin_ack_rcvd = 1'b1;
            tick();
            syn_ack_rcvd = 1'b0;
            fin_ack_rcvd = 1'b0;
            tick();
        end

        // Backpressure: FIN held 5 cycles, ACK pulsed meanwhile stays pending
        seg_ready = 1'b0;
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b0010);
        fin_send = 1'b1;
        tick();
        fin_send = 1'b0;
        n = 0;
        while (!seg_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("hold_wait", 32'(n < 20), 1);
        @(posedge clk);
        #1;
        ack_send = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_valid", 32'(seg_valid), 1);
            chk("hold_seg", 32'({seg_flags, seg_is_data}), 32'b0100);
            @(posedge clk);
            #1;
            ack_send = 1'b0;
        end
        seg_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("hold_ack_pending", 32'(pending_out), 32'b001);
        wait_drain("hold_drain");
        fin_ack_rcvd = 1'b1;
        tick();
        fin_ack_rcvd = 1'b0;
        tick();

        // ACK request in the acceptance cycle of an ACK segment wins
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0010);
        ack_send = 1'b1;
        tick();
        ack_send = 1'b0;
        n = 0;
        while (!seg_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        ack_send = 1'b1;
        @(posedge clk);
        #1;
        ack_send = 1'b0;
        wait_drain("race_drain");
        repeat (2) tick();
        chk("race_pending", 32'(pending_out), 0);

        // SYN retransmits 3 times then exhausts
        timeout_rto_in = 16'd16;
        acc_q.delete();
        ex_cnt = 0;
        repeat (4) exp_q.push_back(4'b1000);
        syn_send = 1'b1;
        tick();
        syn_send = 1'b0;
        n = 0;
        while (ex_cnt == 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("exh_wait", 32'(n < 200), 1);
        repeat (40) @(negedge clk);
        chk("exh_count", 32'(ex_cnt), 1);
        chk("syn_issues", 32'(acc_q.size()), 4);
        chk("exh_queue", 32'(exp_q.size()), 0);
        chk("exh_pending", 32'(pending_out), 0);
        if (acc_q.size() == 4) begin
            // accept -> 17 cycles to reach timer==16 -> pending -> load -> issue
            for (int k = 1; k < 4; k++)
                chk($sformatf("reissue_gap%0d", k), 32'(acc_q[k] - acc_q[k-1]), 32'd19);
            chk("exh_gap", 32'(ex_cyc - acc_q[3]), 32'd18);
        end

        // FIN ack lands exactly in the timeout hit cycle
        acc_q.delete();
        ex_cnt = 0;
        exp_q.push_back(4'b0100);
        fin_send = 1'b1;
        tick();
        fin_send = 1'b0;
        n = 0;
        while (acc_q.size() == 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("fin_accept_wait", 32'(n < 20), 1);
        a = (acc_q.size() != 0) ? acc_q[0] : cyc;
        while (cyc < a + 17) tick();
        fin_ack_rcvd = 1'b1;
        tick();
        fin_ack_rcvd = 1'b0;
        repeat (60) @(negedge clk);
        chk("fin_ack_issues", 32'(acc_q.size()), 1);
        chk("fin_ack_pending", 32'(pending_out), 0);
        chk("fin_ack_exh", 32'(ex_cnt), 0);

        // Reset during ISSUE drops the segment for good
        timeout_rto_in = 16'd0;
        seg_ready = 1'b0;
        syn_send = 1'b1;
        tick();
        syn_send = 1'b0;
        n = 0;
        while (!seg_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rstmid_wait", 32'(n < 20), 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_valid", 32'(seg_valid), 0);
        chk("rstmid_flags", 32'(seg_flags), 0);
        chk("rstmid_is_data", 32'(seg_is_data), 0);
        chk("rstmid_grant", 32'(data_grant), 0);
        chk("rstmid_pending", 32'(pending_out), 0);
        chk("rstmid_exh", 32'(retry_exhausted), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        seg_ready = 1'b1;
        acc_q.delete();
        repeat (20) @(negedge clk);
        chk("rstmid_no_reissue", 32'(acc_q.size()), 0);
        chk("rstmid_idle_valid", 32'(seg_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
